// File: rtl/argmax_8_20.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | argmax_8_20                                                              |
// | Streaming argmax over N signed T-bit words; ready/valid in and out.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module argmax_8_20 #(
  parameter int N    = 8,
  parameter int T    = 20,
  parameter int logN = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    data_in,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [logN-1:0] idx_out,
  output logic [T-1:0]    max_out
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam logic [logN-1:0] c_LAST = logN'(N - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [logN-1:0]        r_cnt;
  logic signed [T-1:0]    r_max;
  logic [logN-1:0]        r_idx;
  logic [logN-1:0]        r_pend_idx;
  logic [T-1:0]           r_pend_max;
  logic                   r_m_valid;
  logic [logN-1:0]        r_idx_out;
  logic [T-1:0]           r_max_out;

  logic                   w_accept;
  logic                   w_first;
  logic                   w_last;
  logic                   w_gt;
  logic                   w_take;
  logic [logN-1:0]        w_cand_idx;
  logic [T-1:0]           w_cand_max;
  logic                   w_out_free;
  logic                   w_load_cand;
  logic                   w_load_pend;
  logic                   w_store_pend;

  assign s_ready    = ~reset && (r_state == COLLECT);
  assign w_accept   = s_valid && s_ready;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == c_LAST);
  assign w_gt       = $signed(data_in) > r_max;
  // The first word of a vector seeds the running max regardless of value.
  assign w_take     = w_first || w_gt;
  assign w_cand_idx = w_take ? r_cnt : r_idx;
  assign w_cand_max = w_take ? data_in : r_max;
  assign w_out_free = ~r_m_valid || m_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_load_cand  = 1'b0;
    w_load_pend  = 1'b0;
    w_store_pend = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_accept && w_last) begin
          if (w_out_free) begin
            w_load_cand = 1'b1;
          end else begin
            w_store_pend = 1'b1;
            w_state_nxt  = HOLD;
          end
        end
      end
      HOLD: begin
        if (m_ready) begin
          w_load_pend = 1'b1;
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= COLLECT;
      r_cnt      <= '0;
      r_max      <= '0;
      r_idx      <= '0;
      r_pend_idx <= '0;
      r_pend_max <= '0;
      r_m_valid  <= 1'b0;
      r_idx_out  <= '0;
      r_max_out  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_take) begin
          r_max <= data_in;
          r_idx <= r_cnt;
        end
      end
      if (w_store_pend) begin
        r_pend_idx <= w_cand_idx;
        r_pend_max <= w_cand_max;
      end
      // A fresh result takes priority over dropping valid on a transfer.
      if (w_load_cand) begin
        r_idx_out <= w_cand_idx;
        r_max_out <= w_cand_max;
        r_m_valid <= 1'b1;
      end else if (w_load_pend) begin
        r_idx_out <= r_pend_idx;
        r_max_out <= r_pend_max;
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign idx_out = r_idx_out;
  assign max_out = r_max_out;

endmodule
`default_nettype wire

// File: tb/tb_argmax_8_20.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_argmax_8_20                                                           |
// | Directed table vectors, backpressure/reset sequences, random stream.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_argmax_8_20;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [19:0] data_in;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  idx_out;
  logic [19:0] max_out;

  argmax_8_20 #(.N(8), .T(20), .logN(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .idx_out (idx_out),
    .max_out (max_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [159:0] words;
    logic [2:0]   idx;
    logic [19:0]  mx;
  } vec_t;

  vec_t tbl [8];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int e, input int f, input int g, input int h,
                              input int ix, input int mx);
    vec_t v;
    int   arr [8];
    arr = '{a, b, c, d, e, f, g, h};
    for (int i = 0; i < 8; i++) v.words[i*20 +: 20] = 20'(arr[i]);
    v.idx = 3'(ix);
    v.mx  = 20'(mx);
    return v;
  endfunction

  function automatic logic [63:0] res(input logic [2:0] ix, input logic [19:0] mx);
    return 64'({ix, mx});
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(5, 3, 9, 1, 0, 9, 2, 7, 2, 9);
    tbl[1] = mk(-425, -35, -506, -100, -106, -357, -367, -242, 1, -35);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 446, 7, 446);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(524287, -524288, 100, 524287, 0, 0, 0, 0, 0, 524287);
    tbl[5] = mk(-524288, -524288, -524288, -524288, -524288, -524288, -524288, -524288, 0, -524288);
    tbl[6] = mk(-1, -2, -3, -4, -5, -6, -7, 0, 7, 0);
    tbl[7] = mk(1, 2, 3, 4, 5, 6, 7, 8, 7, 8);

    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; data_in = '0;
    repeat (3) tick();
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_outputs", res(idx_out, max_out), res(3'd0, 20'd0));
    reset = 1'b0;
    #1;
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Table vectors, back-to-back; odd entries get a junk idle cycle after every word.
    m_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 8; i++) begin
        s_valid = 1'b1;
        data_in = tbl[v].words[i*20 +: 20];
        chk($sformatf("tbl%0d_s_ready_w%0d", v, i), 64'(s_ready), 64'd1);
        tick();
        if (i < 7) chk($sformatf("tbl%0d_no_valid_w%0d", v, i), 64'(m_valid), 64'd0);
        if (v % 2 == 1 && i < 7) begin
          s_valid = 1'b0;
          data_in = 20'h7FFFF;
          tick();
        end
      end
      chk($sformatf("tbl%0d_m_valid", v), 64'(m_valid), 64'd1);
      chk($sformatf("tbl%0d_result", v), res(idx_out, max_out), res(tbl[v].idx, tbl[v].mx));
    end
    s_valid = 1'b0;
    tick();
    chk("drain_m_valid", 64'(m_valid), 64'd0);

    // Backpressure: two vectors with m_ready low.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; data_in = tbl[0].words[i*20 +: 20];
      tick();
    end
    chk("bp_first_valid", 64'(m_valid), 64'd1);
    chk("bp_first_result", res(idx_out, max_out), res(3'd2, 20'd9));
    for (int i = 0; i < 8; i++) begin
      data_in = tbl[1].words[i*20 +: 20];
      if (i < 7) chk($sformatf("bp_ready_w%0d", i), 64'(s_ready), 64'd1);
      tick();
      chk($sformatf("bp_hold_w%0d", i), 64'({m_valid, idx_out, max_out}), 64'({1'b1, 3'd2, 20'd9}));
    end
    chk("bp_hold_s_ready", 64'(s_ready), 64'd0);
    data_in = 20'h7FFFF;
    repeat (2) tick();
    chk("bp_hold_stable", 64'({m_valid, idx_out, max_out, s_ready}), 64'({1'b1, 3'd2, 20'd9, 1'b0}));
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    chk("bp_second_valid", 64'(m_valid), 64'd1);
    chk("bp_second_result", res(idx_out, max_out), 64'({3'd1, 20'(-35)}));
    chk("bp_ready_back", 64'(s_ready), 64'd1);
    tick();
    chk("bp_drop_valid", 64'(m_valid), 64'd0);

    // Reset mid-vector, then a fresh vector.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; data_in = 20'd1000;
      tick();
    end
    s_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; data_in = tbl[1].words[i*20 +: 20];
      tick();
      if (i == 6) chk("midrst_no_valid", 64'(m_valid), 64'd0);
    end
    chk("midrst_result", 64'({m_valid, idx_out, max_out}), 64'({1'b1, 3'd1, 20'(-35)}));
    s_valid = 1'b0;
    tick();

    // Random stream against a golden argmax with a scoreboard queue.
    begin
      int          w [8];
      int          wp = 0, sent = 0, got = 0, cyc = 0, best, bi;
      logic [22:0] expq [$];
      logic [22:0] e;
      logic signed [19:0] tmp;
      for (int i = 0; i < 8; i++) begin
        tmp  = $urandom_range(0, 1) == 1 ? 20'(int'($urandom_range(0, 7)) - 4) : 20'($urandom);
        w[i] = int'(tmp);
      end
      while (got < 1000 && cyc < 60000) begin
        s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
        data_in = s_valid ? 20'(w[wp]) : 20'($urandom);
        m_ready = ($urandom_range(0, 3) != 0);
        if (m_valid && m_ready) begin
          if (expq.size() == 0) begin
            chk("rand_extra_result", 64'(1), 64'(0));
          end else begin
            e = expq.pop_front();
            chk($sformatf("rand_result%0d", got), res(idx_out, max_out), 64'(e));
          end
          got++;
        end
        if (s_valid && s_ready) begin
          wp++;
          if (wp == 8) begin
            best = w[0]; bi = 0;
            for (int i = 1; i < 8; i++) if (w[i] > best) begin best = w[i]; bi = i; end
            expq.push_back({3'(bi), 20'(best)});
            wp = 0; sent++;
            for (int i = 0; i < 8; i++) begin
              tmp  = $urandom_range(0, 1) == 1 ? 20'(int'($urandom_range(0, 7)) - 4) : 20'($urandom);
              w[i] = int'(tmp);
            end
          end
        end
        tick();
        cyc++;
      end
      chk("rand_count", 64'(got), 64'd1000);
      chk("rand_queue_empty", 64'(expq.size()), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/argmax_8_20.md
ARGMAX_8_20 -- requirements
Module: argmax_8_20

Interface
REQ-001 Parameter N, default 8: number of words per input vector (matches the upstream layer's output count).
REQ-002 Parameter T, default 20: word width in bits; words are two's-complement signed.
REQ-003 Parameter logN, default $clog2(N): width of the index output.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_ready  output  1  block can accept a word this cycle.
REQ-008 data_in  input  T  signed input word, the upstream layer's data_out.
REQ-009 m_valid  output  1  result valid.
REQ-010 m_ready  input  1  downstream accepts the result.
REQ-011 idx_out  output  logN  index (0..N-1) of the maximum word in the vector.
REQ-012 max_out  output  T  signed value of the maximum word.

Function
REQ-013 A word transfers on a rising edge when s_valid && s_ready; a result transfers when m_valid && m_ready.
REQ-014 Input words arrive in order, index 0 first; an internal counter cnt (0..N-1) tracks the position of the next word.
REQ-015 State COLLECT: s_ready=1; on each accepted word, cnt increments, wrapping from N-1 to 0.
REQ-016 On the word with cnt==0, running max := data_in and running idx := 0 unconditionally.
REQ-017 On later words, update max/idx only if data_in > running max (signed, strict); ties keep the lower index.
REQ-018 The result includes the Nth word: candidate = (Nth word > running max) ? {N-1, word} : {running idx, running max}.
REQ-019 On acceptance of the Nth word, if the output register is free (m_valid==0, or m_ready==1 in the same cycle), load the candidate into idx_out/max_out; m_valid=1 from the next cycle; stay in COLLECT.
REQ-020 Otherwise, store the candidate in a pending register and go to state HOLD.
REQ-021 State HOLD: s_ready=0; when m_ready==1 (m_valid is 1), load the pending result into the output register, keep m_valid=1, and return to COLLECT.
REQ-022 The latency from acceptance of the Nth word to m_valid is 1 cycle when the output register is free.
REQ-023 While m_valid && !m_ready, idx_out, max_out and m_valid shall hold stable.
REQ-024 On a transfer with no new result loaded in the same cycle, m_valid drops to 0 next cycle; idx_out/max_out may hold their last values.
REQ-025 Back-to-back vectors with m_ready held at 1 sustain one word per cycle with no bubbles; s_ready never drops in COLLECT.
REQ-026 s_valid gaps at any position in the vector do not disturb cnt, max or idx.
REQ-027 Partial vectors have no timeout; the block waits indefinitely for the remaining words.

Reset
REQ-028 While reset==1: s_ready=0, m_valid=0, idx_out=0, max_out=0, cnt=0, state=COLLECT, pending cleared.
REQ-029 Reset asserted mid-vector or in HOLD discards the partial vector and the pending result; the first word after reset is index 0.
REQ-030 s_ready=1 in the first cycle after reset deasserts.

Verification
REQ-031 Inputs 5,3,9,1,0,9,2,7 with m_ready=1 -> m_valid one cycle after the 8th word; idx_out=2, max_out=9 (tie resolves to the lower index).
REQ-032 Inputs -425,-35,-506,-100,-106,-357,-367,-242 -> idx_out=1, max_out=-35 (signed compare).
REQ-033 Max in the last slot: 0,0,0,0,0,0,0,446 -> idx_out=7, max_out=446; all-zero vector -> idx_out=0, max_out=0.
REQ-034 Backpressure: m_ready=0 while two vectors stream in -> first result held stable; s_ready=0 after the 8th word of the second vector (HOLD); raising m_ready for one cycle -> the second result appears next cycle with m_valid still 1; s_ready returns to 1.
REQ-035 Reset pulsed after 4 words of a vector -> no m_valid; the next 8 words form a fresh vector with the correct result.
REQ-036 Random stream of 1000 vectors with random s_valid/m_ready gaps -> results match a golden argmax in order, with no loss or duplication.
